// File: rtl/vfirst_seq_pkg.sv
// Shared vALU definitions for the vfirst.m sequencer: state encoding,
// the "no set bit" result constant and the chunk-counter width helper.
package vfirst_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FETCH  = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;
  localparam state_t ST_RESULT = 2'd3;

  // Wide enough for any result width in use; users take the low bits.
  localparam logic [127:0] NOT_FOUND = '1;

  // Chunk counters must hold the full count 0..2^(idx_bits-dw_bits).
  function automatic int chunk_cnt_w(input int idx_bits, input int dw_bits);
    return idx_bits - dw_bits + 1;
  endfunction

endpackage

// File: rtl/vfirst_seq_if.sv
// Command, mask read-port and result handshakes of the vfirst sequencer.
// master = sequencer side, slave = issue/register-file/writeback side.
interface vfirst_seq_if #(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int DATA_WIDTH_BITS = 6,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int IDX_BITS        = 10
);
  logic                                cmd_valid;
  logic                                cmd_ready;
  logic [IDX_BITS:0]                   cmd_vl;
  logic                                rd_req;
  logic                                rd_gnt;
  logic [IDX_BITS-DATA_WIDTH_BITS-1:0] rd_chunk;
  logic                                rd_resp_valid;
  logic [REQ_DATA_WIDTH-1:0]           rd_resp_data;
  logic                                out_valid;
  logic                                out_ready;
  logic [RESP_DATA_WIDTH-1:0]          out_data;

  modport master (
    input  cmd_valid, cmd_vl, rd_gnt, rd_resp_valid, rd_resp_data, out_ready,
    output cmd_ready, rd_req, rd_chunk, out_valid, out_data
  );

  modport slave (
    output cmd_valid, cmd_vl, rd_gnt, rd_resp_valid, rd_resp_data, out_ready,
    input  cmd_ready, rd_req, rd_chunk, out_valid, out_data
  );
endinterface

// File: rtl/vfirst_chunk_ffs.sv
// Tail-masks one mask chunk to its first i_limit bits and priority-encodes
// the lowest remaining set bit. Purely combinational; the caller registers it.
module vfirst_chunk_ffs #(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int DATA_WIDTH_BITS = 6
) (
  input  logic [REQ_DATA_WIDTH-1:0]  i_data,
  input  logic [DATA_WIDTH_BITS:0]   i_limit,
  output logic                       o_found,
  output logic [DATA_WIDTH_BITS-1:0] o_bit_idx
);
  localparam int LIM_W = DATA_WIDTH_BITS + 1;

  logic [REQ_DATA_WIDTH-1:0] w_masked;

  always_comb begin
    w_masked = '0;
    for (int i = 0; i < REQ_DATA_WIDTH; i++) begin
      w_masked[i] = i_data[i] & (LIM_W'(i) < i_limit);
    end
    o_found   = |w_masked;
    o_bit_idx = '0;
    // Scanning downward leaves the lowest set bit as the final assignment.
    for (int i = REQ_DATA_WIDTH - 1; i >= 0; i--) begin
      if (w_masked[i]) o_bit_idx = DATA_WIDTH_BITS'(i);
    end
  end
endmodule

// File: rtl/vfirst_seq.sv
// vfirst.m sequencer: streams mask chunks from the register file with bounded
// outstanding reads and returns the index of the first set bit below vl.
module vfirst_seq
  import vfirst_seq_pkg::*;
#(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int DATA_WIDTH_BITS = 6,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int IDX_BITS        = 10,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic          clk,
  input logic          rst,
  vfirst_seq_if.master io_bus
);
  localparam int CHUNK_W = IDX_BITS - DATA_WIDTH_BITS;
  localparam int CNT_W   = chunk_cnt_w(IDX_BITS, DATA_WIDTH_BITS);
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]           MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [RESP_DATA_WIDTH-1:0] RES_NONE = NOT_FOUND[RESP_DATA_WIDTH-1:0];

  state_t                     r_state;
  logic [IDX_BITS:0]          r_vl;
  logic [CNT_W-1:0]           r_nchunks;
  logic [CNT_W-1:0]           r_issued;
  logic [CNT_W-1:0]           r_resp_chunk;
  logic [OUT_W-1:0]           r_outst;
  logic [RESP_DATA_WIDTH-1:0] r_res_p1;

  logic [CNT_W-1:0]           w_cmd_nchunks;
  logic [IDX_BITS:0]          w_rem_p0;
  logic [DATA_WIDTH_BITS:0]   w_limit_p0;
  logic                       w_ffs_found_p0;
  logic [DATA_WIDTH_BITS-1:0] w_ffs_idx_p0;
  logic [IDX_BITS-1:0]        w_hit_idx_p0;
  logic [CNT_W-1:0]           w_resp_chunk_nxt;
  logic                       w_resp_take;
  logic                       w_hit_p0;
  logic                       w_last_p0;
  logic                       w_rd_req;
  logic                       w_issue;
  logic [OUT_W-1:0]           w_outst_nxt;

  assign w_cmd_nchunks = io_bus.cmd_vl[IDX_BITS:DATA_WIDTH_BITS]
                       + CNT_W'(|io_bus.cmd_vl[DATA_WIDTH_BITS-1:0]);

  // ---- p0: response cycle, tail mask + lowest-set-bit search ----
  assign w_rem_p0   = r_vl - {r_resp_chunk, {DATA_WIDTH_BITS{1'b0}}};
  assign w_limit_p0 = (|w_rem_p0[IDX_BITS:DATA_WIDTH_BITS])
                    ? {1'b1, {DATA_WIDTH_BITS{1'b0}}}
                    : {1'b0, w_rem_p0[DATA_WIDTH_BITS-1:0]};

  vfirst_chunk_ffs #(
    .REQ_DATA_WIDTH (REQ_DATA_WIDTH),
    .DATA_WIDTH_BITS(DATA_WIDTH_BITS)
  ) u_ffs (
    .i_data   (io_bus.rd_resp_data),
    .i_limit  (w_limit_p0),
    .o_found  (w_ffs_found_p0),
    .o_bit_idx(w_ffs_idx_p0)
  );

  assign w_hit_idx_p0     = {r_resp_chunk[CHUNK_W-1:0], w_ffs_idx_p0};
  assign w_resp_chunk_nxt = r_resp_chunk + 1'b1;
  assign w_last_p0        = (w_resp_chunk_nxt == r_nchunks);

  // Responses are only meaningful while reads of this command are in flight.
  assign w_resp_take = io_bus.rd_resp_valid && (r_outst != '0)
                    && (r_state == ST_FETCH || r_state == ST_DRAIN);
  assign w_hit_p0    = w_resp_take && (r_state == ST_FETCH) && w_ffs_found_p0;

  assign w_rd_req = (r_state == ST_FETCH) && (r_issued < r_nchunks)
                 && (r_outst < MAX_OUT) && !w_hit_p0;
  assign w_issue  = w_rd_req && io_bus.rd_gnt;

  always_comb begin
    w_outst_nxt = r_outst;
    if (w_issue && !w_resp_take)      w_outst_nxt = r_outst + 1'b1;
    else if (!w_issue && w_resp_take) w_outst_nxt = r_outst - 1'b1;
  end

  // ---- p1: registered result and sequencing state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_vl         <= '0;
      r_nchunks    <= '0;
      r_issued     <= '0;
      r_resp_chunk <= '0;
      r_outst      <= '0;
      r_res_p1     <= '0;
    end else begin
      r_outst <= w_outst_nxt;
      if (w_issue) r_issued <= r_issued + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (io_bus.cmd_valid) begin
            r_vl         <= io_bus.cmd_vl;
            r_nchunks    <= w_cmd_nchunks;
            r_issued     <= '0;
            r_resp_chunk <= '0;
            if (io_bus.cmd_vl == '0) begin
              r_res_p1 <= RES_NONE;
              r_state  <= ST_RESULT;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (w_resp_take) begin
            r_resp_chunk <= w_resp_chunk_nxt;
            if (w_hit_p0) begin
              r_res_p1 <= RESP_DATA_WIDTH'(w_hit_idx_p0);
              r_state  <= (w_outst_nxt == '0) ? ST_RESULT : ST_DRAIN;
            end else if (w_last_p0) begin
              r_res_p1 <= RES_NONE;
              r_state  <= ST_RESULT;
            end
          end
        end
        ST_DRAIN: begin
          if (w_outst_nxt == '0) r_state <= ST_RESULT;
        end
        ST_RESULT: begin
          if (io_bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.cmd_ready = (r_state == ST_IDLE) && !rst;
  assign io_bus.rd_req    = w_rd_req;
  assign io_bus.rd_chunk  = r_issued[CHUNK_W-1:0];
  assign io_bus.out_valid = (r_state == ST_RESULT);
  assign io_bus.out_data  = r_res_p1;

endmodule

// File: tb/tb_vfirst_seq.sv
// Directed bench for vfirst_seq: a latency-programmable mask memory, a bit-scan
// reference model, and a per-cycle compare process on the result and read port.
module tb_vfirst_seq;
  localparam int RW = 64;
  localparam int DW = 6;
  localparam int OW = 64;
  localparam int IB = 10;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vfirst_seq_if #(.REQ_DATA_WIDTH(RW), .DATA_WIDTH_BITS(DW),
                  .RESP_DATA_WIDTH(OW), .IDX_BITS(IB)) bus_if ();

  vfirst_seq #(.REQ_DATA_WIDTH(RW), .DATA_WIDTH_BITS(DW), .RESP_DATA_WIDTH(OW),
               .IDX_BITS(IB), .MAX_OUTSTANDING(MO)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus_if)
  );

  typedef struct {
    int due;
    int chunk;
  } rq_t;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] mem [16];
  int          rd_lat = 1;
  bit          gnt_tog = 1'b0;
  bit          inject = 1'b0;
  rq_t         q[$];
  logic [63:0] exp_data = '1;
  int          n_iss = 0;
  int          max_q = 0;
  int          acc_cyc = 0;
  int          res_cyc = 0;
  bit          seen_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: scan mask bits 0..vl-1 in element order.
  function automatic logic [63:0] model(input int vl);
    for (int i = 0; i < vl; i++) begin
      if (mem[i / 64][i % 64]) return 64'(i);
    end
    return '1;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file read port: in-order responses rd_lat cycles after the grant.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      bus_if.rd_gnt        = 1'b0;
      bus_if.rd_resp_valid = 1'b0;
      bus_if.rd_resp_data  = '0;
    end else begin
      bus_if.rd_gnt        = gnt_tog ? cyc[0] : 1'b1;
      bus_if.rd_resp_valid = 1'b0;
      bus_if.rd_resp_data  = '0;
      if (inject) begin
        bus_if.rd_resp_valid = 1'b1;
        bus_if.rd_resp_data  = '1;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        bus_if.rd_resp_valid = 1'b1;
        bus_if.rd_resp_data  = mem[q[0].chunk];
        void'(q.pop_front());
      end
      #1;
      if (bus_if.rd_req && bus_if.rd_gnt)
        q.push_back('{due: cyc + rd_lat, chunk: int'(bus_if.rd_chunk)});
    end
  end

  // Compare process: read ordering, outstanding bound, result vs model.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (bus_if.cmd_valid && bus_if.cmd_ready) begin
        n_iss = 0; max_q = 0; acc_cyc = cyc; seen_valid = 1'b0;
      end
      if (bus_if.rd_req && bus_if.rd_gnt) begin
        chk("rd_chunk_order", 64'(bus_if.rd_chunk), 64'(n_iss[3:0]));
        n_iss++;
      end
      if (q.size() > max_q) max_q = q.size();
      if (bus_if.out_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          res_cyc    = cyc;
        end
        chk("out_data_vs_model", bus_if.out_data, exp_data);
        chk("outstanding_at_result", 64'(q.size()), 64'd0);
        chk("no_rd_req_in_result", 64'(bus_if.rd_req), 64'd0);
      end
    end
  end

  task automatic run_cmd(input string nm, input int vl, input int lat, input bit tog,
                         input logic [63:0] lit, input int min_lat, input int exp_iss,
                         input int stall);
    int t;
    rd_lat   = lat;
    gnt_tog  = tog;
    exp_data = model(vl);
    chk({nm, "_model"}, exp_data, lit);
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_vl    = vl[IB:0];
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    #3;
    t = 0;
    while (!bus_if.out_valid && t < 600) begin
      @(negedge clk); #3;
      t++;
    end
    chk({nm, "_out_valid"}, 64'(bus_if.out_valid), 64'd1);
    if (bus_if.out_valid) begin
      chk({nm, "_out_data"}, bus_if.out_data, lit);
      chk({nm, "_latency_min"}, 64'(res_cyc - acc_cyc >= min_lat), 64'd1);
      repeat (stall) begin
        @(negedge clk); #3;
      end
      chk({nm, "_held_valid"}, 64'(bus_if.out_valid), 64'd1);
      chk({nm, "_held_data"}, bus_if.out_data, lit);
      chk({nm, "_no_bypass"}, 64'(bus_if.cmd_ready), 64'd0);
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      #3;
      chk({nm, "_valid_dropped"}, 64'(bus_if.out_valid), 64'd0);
      chk({nm, "_cmd_ready_back"}, 64'(bus_if.cmd_ready), 64'd1);
      chk({nm, "_reads_issued"}, 64'(n_iss), 64'(exp_iss));
      chk({nm, "_max_outstanding"}, 64'(max_q <= MO), 64'd1);
    end else begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_vl    = '0;
    bus_if.out_ready = 1'b0;
    clear_mem();

    repeat (2) @(negedge clk);
    #3;
    chk("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
    chk("rst_rd_req", 64'(bus_if.rd_req), 64'd0);
    chk("rst_rd_chunk", 64'(bus_if.rd_chunk), 64'd0);
    chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rst_out_data", bus_if.out_data, 64'd0);
    rst = 1'b0;
    @(negedge clk); #3;
    chk("idle_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);

    clear_mem(); mem[0] = 64'h0000_0000_0000_0100;
    run_cmd("t1_hit8", 64, 2, 1'b0, 64'd8, 4, 1, 0);

    clear_mem(); mem[3] = 64'h20;
    run_cmd("t2_vl300", 300, 2, 1'b0, 64'd197, 7, 5, 0);

    clear_mem(); mem[1] = 64'hFFFF_FFFF_FFFF_FFC0;
    run_cmd("t3_tailmask", 70, 2, 1'b0, '1, 0, 2, 0);

    clear_mem(); mem[1] = 64'h1;
    run_cmd("t4_vl65", 65, 2, 1'b0, 64'd64, 5, 2, 0);

    clear_mem(); mem[0] = '1;
    run_cmd("t5_vl0", 0, 2, 1'b0, '1, 1, 0, 0);
    chk("t5_vl0_latency_exact", 64'(res_cyc - acc_cyc), 64'd1);

    clear_mem();
    run_cmd("t6_allzero", 1024, 3, 1'b0, '1, 0, 16, 0);

    clear_mem(); mem[0] = 64'h8000_0000_0000_0000;
    run_cmd("t7_stall", 64, 1, 1'b0, 64'd63, 3, 1, 10);

    // Reset while the next command is mid-fetch with reads in flight.
    clear_mem(); rd_lat = 3; gnt_tog = 1'b0; exp_data = '1;
    @(negedge clk);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_vl    = 11'd1024;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("midfetch_rd_req_active", 64'(bus_if.rd_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
    @(negedge clk); #3;
    chk("midrst_rd_req", 64'(bus_if.rd_req), 64'd0);
    chk("midrst_out_valid", 64'(bus_if.out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk); #3;
    chk("postrst_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
    chk("postrst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("postrst_rd_req", 64'(bus_if.rd_req), 64'd0);
    inject = 1'b1;
    @(negedge clk); #3;
    inject = 1'b0;
    @(negedge clk); #3;
    chk("stray_resp_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("stray_resp_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
    chk("stray_resp_rd_req", 64'(bus_if.rd_req), 64'd0);

    clear_mem(); mem[15] = 64'h0000_0100_0000_0000;
    run_cmd("t8_hit1000", 1024, 5, 1'b1, 64'd1000, 22, 16, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vfirst_seq.md
Name: vfirst_seq

Overview:
- Sequences a vfirst.m operation over a full mask register of up to 2^IDX_BITS bits.
- Fetches the mask in REQ_DATA_WIDTH-bit chunks from the vector register-file read port and keeps up to MAX_OUTSTANDING reads in flight.
- Runs a registered find-first-set on each returned chunk and stops issuing reads once a set bit is found.
- Returns the element index of the first set mask bit below vl, or all-ones (-1) if there is none. Sits between vector issue and the vALU result writeback.

Parameters:
- REQ_DATA_WIDTH, 64: mask chunk width in bits (power of 2).
- DATA_WIDTH_BITS, 6: log2(REQ_DATA_WIDTH).
- RESP_DATA_WIDTH, 64: result width.
- IDX_BITS, 10: element index width; max vl = 2^IDX_BITS.
- MAX_OUTSTANDING, 4: maximum number of chunk reads in flight.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  new vfirst command
- cmd_ready  out  1  sequencer idle and able to accept a command
- cmd_vl  in  IDX_BITS+1  vector length in mask bits, range 0..2^IDX_BITS
- rd_req  out  1  chunk read request
- rd_gnt  in  1  read port accepts rd_req this cycle
- rd_chunk  out  IDX_BITS-DATA_WIDTH_BITS  chunk number requested
- rd_resp_valid  in  1  read data valid; responses return in order, latency >= 1
- rd_resp_data  in  REQ_DATA_WIDTH  mask chunk
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_data  out  RESP_DATA_WIDTH  first index, zero-extended, or all-ones if none found

Behaviour:
- Reset values: cmd_ready=0 during rst, then 1 in IDLE; rd_req=0; rd_chunk=0; out_valid=0; out_data=0. FSM is in IDLE; all counters are 0.
- FSM states: IDLE, FETCH, DRAIN, RESULT.
- IDLE:
  - cmd_ready=1.
  - cmd_valid captures vl and sets nchunks = ceil(vl/REQ_DATA_WIDTH).
  - vl=0: go directly to RESULT with out_data=all-ones; no reads are issued.
  - Otherwise go to FETCH.
- FETCH (issue side):
  - rd_req=1 while issued < nchunks, outstanding < MAX_OUTSTANDING, and found=0.
  - Each cycle with rd_req and rd_gnt both high: rd_chunk increments and outstanding increments.
  - rd_req may drop combinationally on the same cycle a response finds a bit.
- FETCH (response side):
  - Each rd_resp_valid decrements outstanding; outstanding holds if an issue and a response occur in the same cycle.
  - Bits at positions >= vl-(resp_chunk*REQ_DATA_WIDTH) are masked off; this applies only in the last chunk.
  - Lowest set bit of the masked chunk is found, and the result is registered with 1-cycle latency as bit index plus resp_chunk<<DATA_WIDTH_BITS.
  - resp_chunk then increments.
- Found transition: first chunk with any set bit sets found. Go to RESULT if outstanding (after update) is 0, else go to DRAIN.
- All chunks returned, none found: go to RESULT with out_data=all-ones.
- DRAIN: discard remaining responses, no further rd_req, go to RESULT when outstanding reaches 0.
- RESULT:
  - out_valid=1 and out_data is held stable until out_ready; output is never withdrawn once valid.
  - On out_valid && out_ready: go to IDLE, same cycle. cmd_ready rises the next cycle, so there is no back-to-back bypass.
- Ordering guarantee: the result is never presented while reads are outstanding, so stale responses cannot corrupt the next command.
- Result latency: with a fixed read latency L and a hit in chunk k, out_valid is asserted no earlier than k+L+2 cycles after command acceptance.
- Reset mid-operation: FSM returns to IDLE and outstanding is cleared. The read port must be reset in the same cycle; any rd_resp_valid seen in IDLE is ignored.
- Full vl = 2^IDX_BITS: nchunks = 2^(IDX_BITS-DATA_WIDTH_BITS) and rd_chunk wraps to 0 only after the final issue. vl that is not a multiple of REQ_DATA_WIDTH masks the tail bits.

Decomposition:
- Shared vALU package holds:
  - FSM state enum: IDLE, FETCH, DRAIN, RESULT.
  - The NOT_FOUND all-ones constant.
  - The chunk-count width function.
- One sub-module, vfirst_chunk_ffs: combinational tail-masking plus lowest-set-bit priority encoder, outputs {found, bit_idx}. The sequencer registers its output.

Test Plan:
- vl=64, chunk0=0x0000_0000_0000_0100, L=2 -> 1 read issued; out_data=8; found flag causes no further reads.
- vl=300, all chunks 0 except chunk3 bit5 -> 5 chunks fetched; out_data=197; chunk4 response is drained and discarded; outstanding returns to 0 before out_valid.
- vl=70, chunk1=0xFFFF_FFFF_FFFF_FFC0 (set bits only at position 6 and above), chunk0=0 -> tail bits masked; out_data=all-ones.
- vl=0 -> no rd_req asserted; out_valid one cycle after acceptance with out_data=all-ones.
- out_ready held low for 10 cycles in RESULT, then rst asserted mid-FETCH on the next command -> out_data stable for the whole stall; after rst: cmd_ready=1, out_valid=0, rd_req=0, and late responses are ignored.
- rd_gnt toggling 1/0 with L=5, MAX_OUTSTANDING=4, vl=1024, hit at index 1000 -> outstanding never exceeds 4; out_data=1000; rd_chunk never passes 15.
